// File: rtl/scpad_pkg.sv
// Shared types for the scratchpad response tail: response record, requester
// select and the default per-destination FIFO depth.
package scpad_pkg;

   localparam int SCPAD_ID_WIDTH   = 4;
   localparam int SCPAD_TAIL_DEPTH = 2;
   localparam int SCPAD_TAG_WIDTH  = 4;
   localparam int SCPAD_DATA_WIDTH = 32;

   typedef enum logic {
      SRC_BE = 1'b0,
      SRC_FE = 1'b1
   } src_t;

   typedef struct packed {
      src_t                        src;
      logic [SCPAD_TAG_WIDTH-1:0]  tag;
      logic [SCPAD_DATA_WIDTH-1:0] data;
      logic                        wr_ack;
   } res_t;

endpackage

// File: rtl/scpad_tail_fifo.sv
// Small circular FIFO of responses for one requester. Storage, pointers and
// count all clear on reset so the head payload reads as zero afterwards.
module scpad_tail_fifo
   import scpad_pkg::*;
#(
   parameter int DEPTH = SCPAD_TAIL_DEPTH
) (
   input  logic clk,
   input  logic n_rst,
   input  logic push,
   input  res_t wdata,
   output logic valid,
   output res_t rdata,
   input  logic ready,
   output logic full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   res_t             mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             pop;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   assign valid = (count != '0);
   assign full  = (count == FULL_CNT);
   assign rdata = mem[rd_ptr];
   assign pop   = valid && ready;

   // Storage write, pointer advance and occupancy tracking.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= next_ptr(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/scpad_tail.sv
// Scratchpad response tail: steers each completed response to the BE or FE
// FIFO by its src field and raises r_stall while either FIFO is full.
// Optional feature macro: SCPAD_TAIL_PERF_EN adds three wrapping 32-bit
// performance counters (BE pops, FE pops, stalled cycles) and their ports.
module scpad_tail
   import scpad_pkg::*;
#(
   parameter logic [SCPAD_ID_WIDTH-1:0] IDX   = '0,
   parameter int                        DEPTH = SCPAD_TAIL_DEPTH
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        stomach_res_valid,
   input  res_t        stomach_res,
   output logic        be_res_valid,
   output res_t        be_res,
   input  logic        be_res_ready,
   output logic        fe_res_valid,
   output res_t        fe_res,
   input  logic        fe_res_ready,
   output logic        r_stall
`ifdef SCPAD_TAIL_PERF_EN
   ,
   output logic [31:0] be_res_cnt,
   output logic [31:0] fe_res_cnt,
   output logic [31:0] stall_cnt
`endif
);

   logic accept;
   logic be_push;
   logic fe_push;
   logic be_full;
   logic fe_full;

   // Stall ignores the incoming src on purpose: one full side holds both.
   assign r_stall = be_full || fe_full;
   assign accept  = stomach_res_valid && !r_stall;
   assign be_push = accept && (stomach_res.src == SRC_BE);
   assign fe_push = accept && (stomach_res.src != SRC_BE);

   scpad_tail_fifo #(.DEPTH(DEPTH)) u_be_fifo (
      .clk   (clk),
      .n_rst (n_rst),
      .push  (be_push),
      .wdata (stomach_res),
      .valid (be_res_valid),
      .rdata (be_res),
      .ready (be_res_ready),
      .full  (be_full)
   );

   scpad_tail_fifo #(.DEPTH(DEPTH)) u_fe_fifo (
      .clk   (clk),
      .n_rst (n_rst),
      .push  (fe_push),
      .wdata (stomach_res),
      .valid (fe_res_valid),
      .rdata (fe_res),
      .ready (fe_res_ready),
      .full  (fe_full)
   );

   a_be_no_overflow : assert property (@(posedge clk) disable iff (!n_rst) !(be_push && be_full))
      else $error("scpad_tail %0d: push into full BE fifo", IDX);
   a_fe_no_overflow : assert property (@(posedge clk) disable iff (!n_rst) !(fe_push && fe_full))
      else $error("scpad_tail %0d: push into full FE fifo", IDX);

`ifdef SCPAD_TAIL_PERF_EN
   // Wrapping event counters: delivered responses per side and held cycles.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         be_res_cnt <= '0;
         fe_res_cnt <= '0;
         stall_cnt  <= '0;
      end else begin
         if (be_res_valid && be_res_ready) be_res_cnt <= be_res_cnt + 32'd1;
         if (fe_res_valid && fe_res_ready) fe_res_cnt <= fe_res_cnt + 32'd1;
         if (stomach_res_valid && r_stall) stall_cnt  <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_scpad_tail.sv
// Directed bench for scpad_tail (DEPTH=2): table of per-cycle vectors plus
// hand-written sequences for wrap, stall/hold, async reset and counters.
module tb_scpad_tail;
   import scpad_pkg::*;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        stomach_res_valid;
   res_t        stomach_res;
   logic        be_res_valid;
   res_t        be_res;
   logic        be_res_ready;
   logic        fe_res_valid;
   res_t        fe_res;
   logic        fe_res_ready;
   logic        r_stall;
`ifdef SCPAD_TAIL_PERF_EN
   logic [31:0] be_res_cnt;
   logic [31:0] fe_res_cnt;
   logic [31:0] stall_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   scpad_tail #(.IDX('0), .DEPTH(2)) dut (
      .clk               (clk),
      .n_rst             (n_rst),
      .stomach_res_valid (stomach_res_valid),
      .stomach_res       (stomach_res),
      .be_res_valid      (be_res_valid),
      .be_res            (be_res),
      .be_res_ready      (be_res_ready),
      .fe_res_valid      (fe_res_valid),
      .fe_res            (fe_res),
      .fe_res_ready      (fe_res_ready),
      .r_stall           (r_stall)
`ifdef SCPAD_TAIL_PERF_EN
      ,
      .be_res_cnt        (be_res_cnt),
      .fe_res_cnt        (fe_res_cnt),
      .stall_cnt         (stall_cnt)
`endif
   );

   typedef struct {
      logic       v;
      src_t       s;
      logic [3:0] t;
      logic       br;
      logic       fr;
      logic       ebv;
      logic [3:0] ebt;
      logic       efv;
      logic [3:0] eft;
      logic       est;
   } vec_t;

   vec_t tbl [15];

   function automatic logic [31:0] mk_data(input logic [3:0] t);
      return 32'hC0DE_0000 | {28'h0, t};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input src_t s, input logic [3:0] t,
                        input logic br, input logic fr);
      stomach_res_valid = v;
      stomach_res.src    = s;
      stomach_res.tag    = t;
      stomach_res.data   = mk_data(t);
      stomach_res.wr_ack = t[0];
      be_res_ready      = br;
      fe_res_ready      = fr;
   endtask

   task automatic expect_out(input string name, input logic ebv, input logic [3:0] ebt,
                             input logic efv, input logic [3:0] eft, input logic est);
      chk({name, ".be_valid"}, 32'(be_res_valid), 32'(ebv));
      chk({name, ".fe_valid"}, 32'(fe_res_valid), 32'(efv));
      chk({name, ".r_stall"},  32'(r_stall),      32'(est));
      if (ebv) begin
         chk({name, ".be_tag"},  32'(be_res.tag), 32'(ebt));
         chk({name, ".be_data"}, be_res.data,     mk_data(ebt));
         chk({name, ".be_src"},  32'(be_res.src), 32'(SRC_BE));
      end
      if (efv) begin
         chk({name, ".fe_tag"},  32'(fe_res.tag), 32'(eft));
         chk({name, ".fe_data"}, fe_res.data,     mk_data(eft));
         chk({name, ".fe_src"},  32'(fe_res.src), 32'(SRC_FE));
      end
   endtask

   initial begin
      // v  src     t  br fr | ebv ebt efv eft st
      tbl[0]  = '{1'b0, SRC_BE, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0};
      tbl[1]  = '{1'b1, SRC_BE, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0};
      tbl[2]  = '{1'b0, SRC_BE, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0};
      tbl[3]  = '{1'b0, SRC_BE, 4'd0, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0};
      tbl[4]  = '{1'b0, SRC_BE, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0};
      tbl[5]  = '{1'b1, SRC_BE, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0};
      tbl[6]  = '{1'b1, SRC_FE, 4'd1, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0};
      tbl[7]  = '{1'b1, SRC_BE, 4'd2, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 4'd1, 1'b0};
      tbl[8]  = '{1'b1, SRC_FE, 4'd3, 1'b1, 1'b1, 1'b1, 4'd2, 1'b0, 4'd0, 1'b0};
      tbl[9]  = '{1'b1, SRC_BE, 4'd4, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 4'd3, 1'b0};
      tbl[10] = '{1'b1, SRC_FE, 4'd5, 1'b1, 1'b1, 1'b1, 4'd4, 1'b0, 4'd0, 1'b0};
      tbl[11] = '{1'b1, SRC_BE, 4'd6, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 4'd5, 1'b0};
      tbl[12] = '{1'b1, SRC_FE, 4'd7, 1'b1, 1'b1, 1'b1, 4'd6, 1'b0, 4'd0, 1'b0};
      tbl[13] = '{1'b0, SRC_BE, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 4'd7, 1'b0};
      tbl[14] = '{1'b0, SRC_BE, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0};

      n_rst = 1'b0;
      drive(1'b0, SRC_BE, 4'd0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      n_rst = 1'b1;

      // Reset state, first BE response, then alternating BE/FE traffic.
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         expect_out($sformatf("vec%0d", i), tbl[i].ebv, tbl[i].ebt,
                    tbl[i].efv, tbl[i].eft, tbl[i].est);
         drive(tbl[i].v, tbl[i].s, tbl[i].t, tbl[i].br, tbl[i].fr);
      end

      // BE push and pop in the same cycle at count 1, across pointer wrap.
      @(negedge clk); expect_out("wrap0", 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      drive(1'b1, SRC_BE, 4'd1, 1'b0, 1'b0);
      @(negedge clk); expect_out("wrap1", 1'b1, 4'd1, 1'b0, 4'd0, 1'b0);
      drive(1'b1, SRC_BE, 4'd2, 1'b1, 1'b0);
      @(negedge clk); expect_out("wrap2", 1'b1, 4'd2, 1'b0, 4'd0, 1'b0);
      drive(1'b1, SRC_BE, 4'd3, 1'b1, 1'b0);
      @(negedge clk); expect_out("wrap3", 1'b1, 4'd3, 1'b0, 4'd0, 1'b0);
      drive(1'b1, SRC_BE, 4'd4, 1'b1, 1'b0);
      @(negedge clk); expect_out("wrap4", 1'b1, 4'd4, 1'b0, 4'd0, 1'b0);
      drive(1'b0, SRC_BE, 4'd0, 1'b0, 1'b0);
      @(negedge clk); expect_out("wrap5", 1'b1, 4'd4, 1'b0, 4'd0, 1'b0);
      drive(1'b0, SRC_BE, 4'd0, 1'b1, 1'b0);
      @(negedge clk); expect_out("wrap6", 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      drive(1'b0, SRC_BE, 4'd0, 1'b0, 1'b0);

      // Asynchronous reset while each FIFO holds one entry.
      @(negedge clk); drive(1'b1, SRC_BE, 4'd7, 1'b0, 1'b0);
      @(negedge clk); drive(1'b1, SRC_FE, 4'd8, 1'b0, 1'b0);
      @(negedge clk); expect_out("prerst", 1'b1, 4'd7, 1'b1, 4'd8, 1'b0);
      drive(1'b0, SRC_BE, 4'd0, 1'b0, 1'b0);
      #2 n_rst = 1'b0;
      #1;
      expect_out("inrst", 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      chk("inrst.be_res", 32'(be_res == '0), 32'd1);
      chk("inrst.fe_res", 32'(fe_res == '0), 32'd1);
      @(negedge clk); n_rst = 1'b1;
      drive(1'b0, SRC_BE, 4'd0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         expect_out($sformatf("postrst%0d", i), 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      end
      drive(1'b0, SRC_BE, 4'd0, 1'b0, 1'b0);

      // FE full with ready low: stall holds BE tag 9 until FE pops one entry.
      @(negedge clk); expect_out("st0", 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      drive(1'b1, SRC_FE, 4'd5, 1'b0, 1'b0);
      @(negedge clk); expect_out("st1", 1'b0, 4'd0, 1'b1, 4'd5, 1'b0);
      drive(1'b1, SRC_FE, 4'd6, 1'b0, 1'b0);
      @(negedge clk); expect_out("st2", 1'b0, 4'd0, 1'b1, 4'd5, 1'b1);
      drive(1'b1, SRC_BE, 4'd9, 1'b0, 1'b0);
      @(negedge clk); expect_out("st3", 1'b0, 4'd0, 1'b1, 4'd5, 1'b1);
      drive(1'b1, SRC_BE, 4'd9, 1'b0, 1'b0);
      @(negedge clk); expect_out("st4", 1'b0, 4'd0, 1'b1, 4'd5, 1'b1);
      drive(1'b1, SRC_BE, 4'd9, 1'b0, 1'b1);
      @(negedge clk); expect_out("st5", 1'b0, 4'd0, 1'b1, 4'd6, 1'b0);
      drive(1'b1, SRC_BE, 4'd9, 1'b0, 1'b0);
      @(negedge clk); expect_out("st6", 1'b1, 4'd9, 1'b1, 4'd6, 1'b0);
      drive(1'b1, SRC_BE, 4'd10, 1'b1, 1'b1);
      @(negedge clk); expect_out("st7", 1'b1, 4'd10, 1'b0, 4'd0, 1'b0);
      drive(1'b1, SRC_BE, 4'd11, 1'b1, 1'b1);
      @(negedge clk); expect_out("st8", 1'b1, 4'd11, 1'b0, 4'd0, 1'b0);
      drive(1'b1, SRC_BE, 4'd12, 1'b1, 1'b1);
      @(negedge clk); expect_out("st9", 1'b1, 4'd12, 1'b0, 4'd0, 1'b0);
      drive(1'b0, SRC_BE, 4'd0, 1'b1, 1'b1);
      @(negedge clk); expect_out("st10", 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      drive(1'b0, SRC_BE, 4'd0, 1'b0, 1'b0);
`ifdef SCPAD_TAIL_PERF_EN
      chk("perf.be_res_cnt", be_res_cnt, 32'd4);
      chk("perf.fe_res_cnt", fe_res_cnt, 32'd2);
      chk("perf.stall_cnt",  stall_cnt,  32'd3);
`endif

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
